regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 32x32 general-purpose register file between NUM_REQ writeback sources (ALU, load unit, mul/div). It uses a round-robin arbiter with per-requester valid/ready handshakes. It registers the winning write into a one-stage write-port pipeline that drives the register file's write_en/write_addr/write_data directly. It also provides a hold control and a saturating contention counter for performance monitoring.

---
 rtl/regfile_wb_arbiter_if.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles the writeback request handshake and the register-file write port.
//   slave  : the arbiter (consumes requests, drives the write port/status)
//   master : the surrounding pipeline / register file side
//   Signals:
//     req_valid/req_addr/req_data : per-requester write requests (packed)
//     req_ready                   : one-hot or zero grant
//     rf_write_en/addr/data       : registered register-file write port
//     wb_valid/wb_id              : write-stage occupancy and owner
interface regfile_wb_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 32
);
  localparam int unsigned IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rf_write_en;
  logic [AW-1:0]         rf_write_addr;
  logic [DW-1:0]         rf_write_data;
  logic                  wb_valid;
  logic [IDW-1:0]        wb_id;

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_write_en, rf_write_addr, rf_write_data, wb_valid, wb_id
  );

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_write_en, rf_write_addr, rf_write_data, wb_valid, wb_id
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Round-robin arbiter sharing the register-file write port between NUM_REQ
//   writeback sources, followed by a one-stage registered write port.
//   Ports:
//     clk, rst_n   : clock (rising edge), asynchronous active-low reset
//     hold         : suppress all grants this cycle
//     bus (slave)  : request handshakes, register-file write port, wb status
//     conflict_cnt : saturating count of cycles with >=2 requests and no hold
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned AW            = 5,
  parameter int unsigned DW            = 32,
  parameter bit          ZERO_SUPPRESS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  regfile_wb_arbiter_if.slave  bus,
  output logic [15:0]          conflict_cnt
);
  localparam int unsigned IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               wb_valid_q;
  logic [IDW-1:0]     wb_id_q, wb_id_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      data_q, data_d;
  logic               we_q, we_d;
  logic [15:0]        cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic               found;
  int unsigned        gidx;
  int unsigned        idx;
  int unsigned        nvalid;

  // Arbitration depends only on req_valid, hold and rr_ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = 0;
    idx   = 0;
    if (!hold) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!found && bus.req_valid[idx]) begin
          found = 1'b1;
          gidx  = idx;
        end
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  // Next-state of the write stage; rf_write_en is registered from these
  // so it never glitches on the address compare.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wb_id_d  = wb_id_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (found) begin
      rr_ptr_d = (gidx == NUM_REQ - 1) ? '0 : IDW'(gidx + 1);
      wb_id_d  = IDW'(gidx);
      addr_d   = bus.req_addr[gidx*AW +: AW];
      data_d   = bus.req_data[gidx*DW +: DW];
    end
    we_d = found && !(ZERO_SUPPRESS && (addr_d == '0));
  end

  always_comb begin
    nvalid = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      nvalid = nvalid + int'(bus.req_valid[i]);
    end
    cnt_d = cnt_q;
    if (!hold && (nvalid >= 2) && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_id_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= found;
      wb_id_q    <= wb_id_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.req_ready     = grant;
  assign bus.rf_write_en   = we_q;
  assign bus.rf_write_addr = addr_q;
  assign bus.rf_write_data = data_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_id         = wb_id_q;
  assign conflict_cnt      = cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed bench for regfile_wb_arbiter (NUM_REQ=3, AW=5, DW=32,
//   ZERO_SUPPRESS=1) with a behavioural 32x32 register file on the write port.
module tb_regfile_wb_arbiter;
  logic        clk;
  logic        rst_n;
  logic        hold;
  logic [15:0] conflict_cnt;
  logic [31:0] regs [32];

  int n_checks;
  int n_errors;

  regfile_wb_arbiter_if #(.NUM_REQ(3), .AW(5), .DW(32)) bus ();

  regfile_wb_arbiter #(
    .NUM_REQ      (3),
    .AW           (5),
    .DW           (32),
    .ZERO_SUPPRESS(1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (hold),
    .bus         (bus),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: captures on the edge while write_en is high.
  always @(posedge clk) begin
    if (bus.rf_write_en) regs[bus.rf_write_addr] <= bus.rf_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    hold          = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_valid[i]      = 1'b1;
    bus.req_addr[i*5 +: 5]  = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int r = 0; r < 32; r++) regs[r] = '0;
    rst_n = 1'b0;
    clear_inputs();

    // ---- single write from requester 1 ----
    do_reset();
    #1;
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_we",       32'(bus.rf_write_en), 32'd0);
    check("rst_addr",     32'(bus.rf_write_addr), 32'd0);
    check("rst_data",     bus.rf_write_data, 32'd0);
    check("rst_id",       32'(bus.wb_id), 32'd0);
    check("rst_cnt",      32'(conflict_cnt), 32'd0);
    check("rst_ready",    32'(bus.req_ready), 32'd0);
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    #1 check("t1_ready", 32'(bus.req_ready), 32'b010);
    @(negedge clk);
    clear_inputs();
    #1;
    check("t1_we",   32'(bus.rf_write_en), 32'd1);
    check("t1_addr", 32'(bus.rf_write_addr), 32'd5);
    check("t1_data", bus.rf_write_data, 32'hDEAD_BEEF);
    check("t1_id",   32'(bus.wb_id), 32'd1);
    @(negedge clk);
    check("t1_reg5", regs[5], 32'hDEAD_BEEF);
    check("t1_we_off", 32'(bus.rf_write_en), 32'd0);
    check("t1_wbv_off", 32'(bus.wb_valid), 32'd0);

    // ---- all three valid for 9 cycles ----
    do_reset();
    set_req(0, 5'd1, 32'h100);
    set_req(1, 5'd2, 32'h200);
    set_req(2, 5'd3, 32'h300);
    for (int c = 0; c < 9; c++) begin
      #1;
      check("rr_grant", 32'(bus.req_ready), 32'(3'b001 << (c % 3)));
      if (c > 0) begin
        check("rr_wbv", 32'(bus.wb_valid), 32'd1);
        check("rr_id",  32'(bus.wb_id), 32'((c - 1) % 3));
      end
      @(negedge clk);
    end
    clear_inputs();
    #1;
    check("rr_last_id", 32'(bus.wb_id), 32'd2);
    check("rr_last_addr", 32'(bus.rf_write_addr), 32'd3);
    check("rr_cnt", 32'(conflict_cnt), 32'd9);

    // ---- x0 write suppressed ----
    do_reset();
    set_req(2, 5'd0, 32'h1234);
    #1 check("x0_ready", 32'(bus.req_ready), 32'b100);
    @(negedge clk);
    clear_inputs();
    #1;
    check("x0_wbv", 32'(bus.wb_valid), 32'd1);
    check("x0_id",  32'(bus.wb_id), 32'd2);
    check("x0_we",  32'(bus.rf_write_en), 32'd0);
    @(negedge clk);
    check("x0_reg0", regs[0], 32'd0);

    // ---- hold for 3 cycles with requesters 0 and 1 valid ----
    do_reset();
    hold = 1'b1;
    set_req(0, 5'd9, 32'hA5A5_0009);
    set_req(1, 5'd10, 32'hA5A5_000A);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hold_ready", 32'(bus.req_ready), 32'd0);
      check("hold_we",    32'(bus.rf_write_en), 32'd0);
      @(negedge clk);
    end
    check("hold_cnt", 32'(conflict_cnt), 32'd0);
    hold = 1'b0;
    #1 check("hold_release_ready", 32'(bus.req_ready), 32'b001);
    @(negedge clk);
    clear_inputs();
    #1;
    check("hold_release_we",   32'(bus.rf_write_en), 32'd1);
    check("hold_release_addr", 32'(bus.rf_write_addr), 32'd9);
    check("hold_release_cnt",  32'(conflict_cnt), 32'd1);

    // ---- counter saturation ----
    do_reset();
    set_req(0, 5'd11, 32'h11);
    set_req(2, 5'd12, 32'h12);
    repeat (65534) @(negedge clk);
    check("sat_fffe", 32'(conflict_cnt), 32'h0000_FFFE);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("sat_ffff", 32'(conflict_cnt), 32'h0000_FFFF);
    end
    clear_inputs();

    // ---- reset right after a transfer to addr 7 ----
    do_reset();
    set_req(0, 5'd7, 32'h7777_7777);
    @(posedge clk);
    #2;
    clear_inputs();
    check("rr7_we_before", 32'(bus.rf_write_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr7_we",   32'(bus.rf_write_en), 32'd0);
    check("rr7_wbv",  32'(bus.wb_valid), 32'd0);
    check("rr7_addr", 32'(bus.rf_write_addr), 32'd0);
    check("rr7_data", bus.rf_write_data, 32'd0);
    check("rr7_id",   32'(bus.wb_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rr7_reg7", regs[7], 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
